// File: rtl/key_entry_ctrl_if.sv
// Keypad, button and display/load signals of the alarm-clock key entry block.
// master drives keystrokes and buttons; slave is the entry controller.
interface key_entry_ctrl_if;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key_ms_hr;
    logic [3:0] key_ls_hr;
    logic [3:0] key_ms_min;
    logic [3:0] key_ls_min;
    logic       show_new_time;
    logic       show_a;
    logic       load_new_a;
    logic       load_new_c;
    logic       entry_error;

    modport master (
        output one_second, key_valid, key, alarm_button, time_button,
        input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
        input  show_new_time, show_a, load_new_a, load_new_c, entry_error
    );

    modport slave (
        input  one_second, key_valid, key, alarm_button, time_button,
        output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
        output show_new_time, show_a, load_new_a, load_new_c, entry_error
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: shifts BCD digits into an HH:MM buffer and
// issues load strobes for current time or alarm on a legal, complete entry.
module key_entry_ctrl #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic             clock,
    input  logic             reset,
    key_entry_ctrl_if.slave  kb
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [1:0] {
        SHOW_TIME,
        KEY_ENTRY,
        LOAD
    } state_t;

    state_t        state;
    logic          alarm_q;
    logic          time_q;
    logic          press_a;
    logic          press_t;
    logic [2:0]    digit_cnt;
    logic [TW-1:0] timer;
    logic          digit_ok;
    logic          any_press;
    logic          one_press;
    logic          buf_legal;

    function automatic logic legal_hhmm(
        input logic [3:0] mh,
        input logic [3:0] lh,
        input logic [3:0] mm,
        input logic [3:0] lm
    );
        logic ok;
        ok = (mh <= 4'd2) && (lh <= 4'd9);
        if (mh == 4'd2)
            ok = ok && (lh <= 4'd3);
        ok = ok && (mm <= 4'd5) && (lm <= 4'd9);
        return ok;
    endfunction

    assign digit_ok  = kb.key_valid && (kb.key <= 4'd9);
    assign any_press = press_a | press_t;
    assign one_press = press_a ^ press_t;
    assign buf_legal = legal_hhmm(kb.key_ms_hr, kb.key_ls_hr,
                                  kb.key_ms_min, kb.key_ls_min);

    // Presses are registered edges, so a strobe lands two cycles after the rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= SHOW_TIME;
            alarm_q          <= kb.alarm_button;
            time_q           <= kb.time_button;
            press_a          <= 1'b0;
            press_t          <= 1'b0;
            digit_cnt        <= '0;
            timer            <= '0;
            kb.key_ms_hr     <= '0;
            kb.key_ls_hr     <= '0;
            kb.key_ms_min    <= '0;
            kb.key_ls_min    <= '0;
            kb.show_new_time <= 1'b0;
            kb.show_a        <= 1'b0;
            kb.load_new_a    <= 1'b0;
            kb.load_new_c    <= 1'b0;
            kb.entry_error   <= 1'b0;
        end else begin
            alarm_q        <= kb.alarm_button;
            time_q         <= kb.time_button;
            press_a        <= kb.alarm_button & ~alarm_q;
            press_t        <= kb.time_button & ~time_q;
            kb.load_new_a  <= 1'b0;
            kb.load_new_c  <= 1'b0;
            kb.entry_error <= 1'b0;

            unique case (state)
                SHOW_TIME: begin
                    kb.show_new_time <= 1'b0;
                    kb.show_a        <= kb.alarm_button;
                    // A keystroke coincident with a press is dropped.
                    if (!any_press && digit_ok) begin
                        kb.key_ms_hr     <= 4'd0;
                        kb.key_ls_hr     <= 4'd0;
                        kb.key_ms_min    <= 4'd0;
                        kb.key_ls_min    <= kb.key;
                        digit_cnt        <= 3'd1;
                        timer            <= '0;
                        kb.show_new_time <= 1'b1;
                        kb.show_a        <= 1'b0;
                        state            <= KEY_ENTRY;
                    end
                end

                KEY_ENTRY: begin
                    kb.show_new_time <= 1'b1;
                    kb.show_a        <= 1'b0;
                    if (any_press) begin
                        if (one_press && digit_cnt == 3'd4 && buf_legal) begin
                            kb.load_new_a <= press_a;
                            kb.load_new_c <= press_t;
                            state         <= LOAD;
                        end else begin
                            kb.entry_error <= 1'b1;
                            timer          <= '0;
                        end
                    end else if (digit_ok) begin
                        kb.key_ms_hr  <= kb.key_ls_hr;
                        kb.key_ls_hr  <= kb.key_ms_min;
                        kb.key_ms_min <= kb.key_ls_min;
                        kb.key_ls_min <= kb.key;
                        if (digit_cnt != 3'd4)
                            digit_cnt <= digit_cnt + 3'd1;
                        timer <= '0;
                    end else if (kb.one_second) begin
                        if (timer == TW'(TIMEOUT_SEC - 1)) begin
                            kb.key_ms_hr     <= '0;
                            kb.key_ls_hr     <= '0;
                            kb.key_ms_min    <= '0;
                            kb.key_ls_min    <= '0;
                            digit_cnt        <= '0;
                            timer            <= '0;
                            kb.show_new_time <= 1'b0;
                            state            <= SHOW_TIME;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end

                LOAD: begin
                    kb.key_ms_hr     <= '0;
                    kb.key_ls_hr     <= '0;
                    kb.key_ms_min    <= '0;
                    kb.key_ls_min    <= '0;
                    digit_cnt        <= '0;
                    timer            <= '0;
                    kb.show_new_time <= 1'b0;
                    kb.show_a        <= 1'b0;
                    state            <= SHOW_TIME;
                end

                default: begin
                    state <= SHOW_TIME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: expected strobes are queued when
// buttons are pressed and popped when the controller emits them.
module tb_key_entry_ctrl;

    localparam int TO = 10;
    localparam logic [1:0] EV_C = 2'd1;
    localparam logic [1:0] EV_A = 2'd2;
    localparam logic [1:0] EV_E = 2'd3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;

    logic [17:0] exp_q[$];
    logic [17:0] obs_ev;
    logic [1:0]  obs_kind;

    key_entry_ctrl_if kb();

    key_entry_ctrl #(.TIMEOUT_SEC(TO)) dut (
        .clock (clock),
        .reset (reset),
        .kb    (kb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] kbuf();
        return {kb.key_ms_hr, kb.key_ls_hr, kb.key_ms_min, kb.key_ls_min};
    endfunction

    // Every strobe must match the head of the queue; extra ones fail.
    always @(negedge clock) begin
        if (!reset && (kb.load_new_a || kb.load_new_c || kb.entry_error)) begin
            case ({kb.load_new_c, kb.load_new_a, kb.entry_error})
                3'b100:  obs_kind = EV_C;
                3'b010:  obs_kind = EV_A;
                3'b001:  obs_kind = EV_E;
                default: obs_kind = 2'd0;
            endcase
            obs_ev = {obs_kind, kbuf()};
            if (exp_q.size() == 0)
                check("unexpected_strobe", 32'(obs_ev), 32'd0);
            else
                check("strobe", 32'(obs_ev), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key_in(input logic [3:0] d);
        kb.key       = d;
        kb.key_valid = 1'b1;
        step();
        kb.key_valid = 1'b0;
        kb.key       = 4'd0;
    endtask

    task automatic keys4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--)
            key_in(v[i*4 +: 4]);
    endtask

    task automatic press(input bit alarm);
        if (alarm) kb.alarm_button = 1'b1;
        else       kb.time_button  = 1'b1;
        step(3);
        kb.alarm_button = 1'b0;
        kb.time_button  = 1'b0;
        step(2);
    endtask

    task automatic sec_pulse();
        kb.one_second = 1'b1;
        step();
        kb.one_second = 1'b0;
        step();
    endtask

    function automatic logic [20:0] all_outs();
        return {kbuf(), kb.show_new_time, kb.show_a,
                kb.load_new_a, kb.load_new_c, kb.entry_error};
    endfunction

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        reset           = 1'b1;
        kb.one_second   = 1'b0;
        kb.key_valid    = 1'b0;
        kb.key          = 4'd0;
        kb.alarm_button = 1'b0;
        kb.time_button  = 1'b0;
        step(3);
        reset = 1'b0;
        step();
        check("reset_outs", 32'(all_outs()), 32'd0);

        keys4(16'h1234);
        check("entry_1234", 32'(kbuf()), 32'h1234);
        check("snt_entry", 32'(kb.show_new_time), 32'd1);
        exp_q.push_back({EV_C, 16'h1234});
        press(1'b0);
        check("clear_after_load", 32'(kbuf()), 32'h0);
        check("snt_after_load", 32'(kb.show_new_time), 32'd0);

        keys4(16'h0730);
        exp_q.push_back({EV_A, 16'h0730});
        press(1'b1);
        check("clear_after_alarm", 32'(kbuf()), 32'h0);

        keys4(16'h2500);
        exp_q.push_back({EV_E, 16'h2500});
        press(1'b0);
        check("kept_2500", 32'(kbuf()), 32'h2500);
        check("snt_after_err", 32'(kb.show_new_time), 32'd1);
        keys4(16'h2359);
        exp_q.push_back({EV_C, 16'h2359});
        press(1'b0);
        check("clear_2359", 32'(kbuf()), 32'h0);

        for (int d = 1; d <= 5; d++)
            key_in(4'(d));
        check("five_digits", 32'(kbuf()), 32'h2345);
        exp_q.push_back({EV_C, 16'h2345});
        press(1'b0);

        key_in(4'd1);
        key_in(4'd2);
        exp_q.push_back({EV_E, 16'h0012});
        press(1'b0);
        check("short_kept", 32'(kbuf()), 32'h0012);

        for (int i = 0; i < TO - 2; i++)
            sec_pulse();
        kb.one_second = 1'b1;
        kb.key_valid  = 1'b1;
        kb.key        = 4'd7;
        step();
        kb.one_second = 1'b0;
        kb.key_valid  = 1'b0;
        kb.key        = 4'd0;
        step();
        check("key_at_tick", 32'(kbuf()), 32'h0127);
        for (int i = 0; i < TO - 1; i++)
            sec_pulse();
        check("no_timeout_buf", 32'(kbuf()), 32'h0127);
        check("no_timeout_snt", 32'(kb.show_new_time), 32'd1);
        sec_pulse();
        check("timeout_buf", 32'(kbuf()), 32'h0);
        check("timeout_snt", 32'(kb.show_new_time), 32'd0);

        kb.alarm_button = 1'b1;
        step(2);
        check("show_a_held", 32'(kb.show_a), 32'd1);
        check("snt_view_alarm", 32'(kb.show_new_time), 32'd0);
        kb.alarm_button = 1'b0;
        step(2);
        check("show_a_rel", 32'(kb.show_a), 32'd0);

        key_in(4'd12);
        step();
        check("bad_key_buf", 32'(kbuf()), 32'h0);
        check("bad_key_snt", 32'(kb.show_new_time), 32'd0);

        key_in(4'd5);
        key_in(4'd6);
        check("pre_reset_buf", 32'(kbuf()), 32'h0056);
        reset = 1'b1;
        step();
        check("mid_reset_outs", 32'(all_outs()), 32'd0);
        reset = 1'b0;
        step(4);
        check("after_reset_outs", 32'(all_outs()), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
